seg_scan_arbiter: RTL and testbench
===================================

# seg_scan_arbiter

Scan controller and source arbiter for the 4-digit seven-segment display. Two requesters (e.g. register-file debug view and datapath result) each offer a 16-bit hex word. The block grants the display to one requester at a time, switching only on frame boundaries. It generates the refresh prescaler and the digit/anode scan sequence, so no frame mixes nibbles from two sources.

## Interface
- DIV, 50000, clk cycles per digit slot (≥2)
- HOLD_FRAMES, 4, minimum frames a grantee keeps the display while the other source is requesting (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  req[i]=1: source i wants the display; level, held while wanted
- data0  in  16  source 0 word, nibble 3 = data0[15:12]
- data1  in  16  source 1 word
- grant  out  2  one-hot owner, 00 = idle; registered
- digit  out  4  nibble for currently enabled digit; registered
- anode  out  4  active-low digit enable; registered
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler: pcnt counts 0..DIV-1 and wraps. tick = (pcnt == DIV-1).
- Scan index idx (2 bits) increments on tick and wraps 3→0. The frame boundary is the tick where idx == 3.
- Slot mapping, applied to the latched word W:
  - idx 0 → W[15:12], anode 0111
  - idx 1 → W[11:8], anode 1011
  - idx 2 → W[7:4], anode 1101
  - idx 3 → W[3:0], anode 1110
- States:
  - IDLE: grant 00, anode 1111, digit 0000.
  - OWN0: grant 01.
  - OWN1: grant 10.
- All state, grant and W updates happen only at a frame boundary.
- Transitions at a frame boundary:
  - IDLE: if exactly one req is set, grant that source. If both are set, grant the source that is not last_served.
  - OWNi, req[i]=0: go to OWNj if req[j]=1, else IDLE.
  - OWNi, req[i]=1, req[j]=1, hcnt ≥ HOLD_FRAMES: go to OWNj.
  - Otherwise stay.
- Word latch: at every boundary where the next state is OWNi, W ← data_i (sampled that cycle). Source data changes mid-frame are not shown until the next boundary.
- Hold counter hcnt:
  - Set to 1 on entering OWNi from any other state.
  - Increments (saturating at HOLD_FRAMES) at each boundary where the state stays OWNi.
  - Cleared to 0 in IDLE.
- last_served ← i whenever OWNi is entered.
- Scanning (pcnt, idx) runs continuously in all states. Only the output values are blanked in IDLE.

## Timing
- Reset (reset=0) asynchronously forces:
  - pcnt=0, idx=0, state IDLE, hcnt=0, last_served=1 (source 0 wins the first tie), W=0.
  - grant=00, digit=0000, anode=1111, frame_done=0.
- Outputs are registered:
  - digit and anode reflect idx and state one cycle after the change, so the first slot after a boundary appears on the cycle following the tick.
  - grant and the state update together, on the same edge as the boundary tick.
- frame_done is high for the one cycle after the boundary tick, concurrent with the new grant.
- Frame length = 4·DIV cycles.
- Request-to-display latency: from req rising in IDLE to the first non-blank anode is at most 4·DIV+1 cycles.
- req edges between boundaries have no effect until the next boundary. A pulse that rises and falls between boundaries is ignored.
- Both req rising on the same cycle is resolved by last_served.
- Reset mid-frame blanks the display immediately, and scanning restarts at idx 0.

## Test plan
All scenarios run with DIV=4 and HOLD_FRAMES=2, so one frame = 16 cycles.
- Reset release, req=00 → grant 00 and anode 1111 for 40 cycles. frame_done pulses every 16 cycles.
- req=01, data0=16'h1A2B → grant 01 at the first boundary. digit/anode then cycle 1/0111, A/1011, 2/1101, B/1110, 4 cycles each.
- req=11 from IDLE after reset → grant 01 first. Grant switches to 10 after 2 frames and back to 01 after 2 more (round-robin, hold honoured).
- Owner 0 shown, data0 changed 16'h1111→16'h2222 at idx 1 → the remaining slots of that frame still show 1. The next frame shows 2.
- Owner 1, req[1] dropped mid-frame with req[0]=0 → digits continue to the boundary, then grant 00 and anode 1111.
- Assert reset=0 mid-frame while owning → within the same cycle grant=00, anode=1111, digit=0. After release with req held, the grant returns at the first boundary 16 cycles later.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: refresh prescaler, 4-digit scan sequencer and two-source
// display arbiter. Ownership and the displayed word change only on frame
// boundaries, so a frame never mixes nibbles from two sources.
module seg_scan_arbiter #(
  parameter int DIV         = 50000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  grant,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  // Encoding doubles as the one-hot grant value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          last_q, last_d;
  logic [15:0]   w_q, w_d;
  logic [1:0]    grant_q, grant_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    anode_q, anode_d;
  logic          fd_q, fd_d;

  logic tick;
  logic boundary;
  logic hold_done;

  assign tick      = (pcnt_q == PW'(DIV - 1));
  assign boundary  = tick && (idx_q == 2'd3);
  assign hold_done = (hcnt_q >= HW'(HOLD_FRAMES));

  // Free-running prescaler and digit scan index, independent of ownership.
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
  end

  // Arbitration, hold counting and word latch, all gated to the frame boundary.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    last_d  = last_q;
    w_d     = w_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          case (req)
            2'b01:   state_d = OWN0;
            2'b10:   state_d = OWN1;
            2'b11:   state_d = last_q ? OWN0 : OWN1;
            default: state_d = IDLE;
          endcase
        end
        OWN0: begin
          if (!req[0])                 state_d = req[1] ? OWN1 : IDLE;
          else if (req[1] && hold_done) state_d = OWN1;
        end
        OWN1: begin
          if (!req[1])                 state_d = req[0] ? OWN0 : IDLE;
          else if (req[0] && hold_done) state_d = OWN0;
        end
        default: state_d = IDLE;
      endcase

      if (state_d == IDLE)          hcnt_d = '0;
      else if (state_d != state_q)  hcnt_d = HW'(1);
      else if (!hold_done)          hcnt_d = hcnt_q + HW'(1);

      if (state_d == OWN0) begin
        w_d = data0;
        if (state_q != OWN0) last_d = 1'b0;
      end else if (state_d == OWN1) begin
        w_d = data1;
        if (state_q != OWN1) last_d = 1'b1;
      end
    end
  end

  // Registered output values: grant follows the next state, the slot follows
  // the current scan index and owner so it lags the index by one cycle.
  always_comb begin
    grant_d = {state_d == OWN1, state_d == OWN0};
    fd_d    = boundary;
    case (idx_q)
      2'd0:    begin digit_d = w_q[15:12]; anode_d = 4'b0111; end
      2'd1:    begin digit_d = w_q[11:8];  anode_d = 4'b1011; end
      2'd2:    begin digit_d = w_q[7:4];   anode_d = 4'b1101; end
      default: begin digit_d = w_q[3:0];   anode_d = 4'b1110; end
    endcase
    if (state_q == IDLE) begin
      digit_d = 4'h0;
      anode_d = 4'b1111;
    end
  end

  // All state and output registers; reset blanks the display at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q  <= '0;
      idx_q   <= 2'd0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      last_q  <= 1'b1;
      w_q     <= 16'h0000;
      grant_q <= 2'b00;
      digit_q <= 4'h0;
      anode_q <= 4'b1111;
      fd_q    <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      last_q  <= last_d;
      w_q     <= w_d;
      grant_q <= grant_d;
      digit_q <= digit_d;
      anode_q <= anode_d;
      fd_q    <= fd_d;
    end
  end

  assign grant      = grant_q;
  assign digit      = digit_q;
  assign anode      = anode_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter with DIV=4, HOLD_FRAMES=2 (16-cycle frames).
// Stimulus pushes per-cycle expected display values; a monitor compares at negedge.
module tb_seg_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [1:0]  grant;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        frame_done;

  seg_scan_arbiter #(.DIV(4), .HOLD_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .grant      (grant),
    .digit      (digit),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  g;
    logic [3:0]  d;
    logic [3:0]  a;
    logic        fd;
    logic        chk;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Blank display expected at cycle c (reset or idle).
  task automatic expect_blank(input int c, input string tag);
    exp_t e;
    e.cyc = c; e.g = 2'b00; e.d = 4'h0; e.a = 4'b1111; e.fd = 1'b0; e.chk = 1'b1; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Frame whose boundary edge is cycle b: grant g from b, slots of w from b+1.
  task automatic expect_frame(input int b, input logic [1:0] g, input logic [15:0] w,
                              input logic fd, input int n, input string tag);
    logic [3:0] one;
    one = 4'b1000;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   s;
      s     = (k == 0) ? 0 : (k - 1) / 4;
      e.cyc = b + k;
      e.g   = g;
      e.fd  = (k == 0) ? fd : 1'b0;
      e.chk = (k != 0);
      e.tag = tag;
      if (g == 2'b00) begin
        e.d = 4'h0;
        e.a = 4'b1111;
      end else begin
        e.d = 4'(w >> (4 * (3 - s)));
        e.a = ~(one >> s);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  // Monitor: pop and compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed check cyc=%0d now=%0d", e.tag, e.cyc, cyc);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      ok = (grant === e.g) && (frame_done === e.fd) &&
           (!e.chk || ((digit === e.d) && (anode === e.a)));
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc=%0d got grant=%b digit=%h anode=%b fd=%b expected grant=%b digit=%h anode=%b fd=%b",
                 e.tag, cyc, grant, digit, anode, frame_done, e.g, e.d, e.a, e.fd);
      end
    end
  end

  initial begin
    int base, b3, r, base3;
    reset = 1'b0;
    req   = 2'b00;
    data0 = 16'h0000;
    data1 = 16'h0000;

    // Reset state, then idle frames with a short ignored request pulse.
    step(3);
    expect_blank(cyc, "rst_state");
    expect_blank(cyc + 1, "rst_state");
    step(1);
    base  = cyc;
    reset = 1'b1;
    expect_frame(base,      2'b00, 16'h0, 1'b0, 16, "idle0");
    expect_frame(base + 16, 2'b00, 16'h0, 1'b1, 16, "idle1");
    expect_frame(base + 32, 2'b00, 16'h0, 1'b1, 16, "idle2");
    goto(base + 20); req = 2'b01;
    goto(base + 23); req = 2'b00;

    // Single requester 0.
    goto(base + 40);
    req   = 2'b01;
    data0 = 16'h1A2B;
    expect_frame(base + 48, 2'b01, 16'h1A2B, 1'b1, 16, "own0_a");
    expect_frame(base + 64, 2'b01, 16'h1A2B, 1'b1, 16, "own0_b");

    // Mid-frame data change is held off until the next boundary.
    goto(base + 72);
    data0 = 16'h1111;
    b3 = base + 80;
    expect_frame(b3, 2'b01, 16'h1111, 1'b1, 16, "hold_old");
    goto(b3 + 5);
    data0 = 16'h2222;
    expect_frame(b3 + 16, 2'b01, 16'h2222, 1'b1, 6, "new_word");

    // Reset mid-frame while owning, request held across it.
    goto(b3 + 22);
    reset = 1'b0;
    expect_blank(b3 + 22, "rst_mid");
    expect_blank(b3 + 23, "rst_mid");
    expect_blank(b3 + 24, "rst_mid");
    goto(b3 + 24);
    r = cyc;
    reset = 1'b1;
    expect_frame(r,      2'b00, 16'h0,    1'b0, 16, "rst_idle");
    expect_frame(r + 16, 2'b01, 16'h2222, 1'b1, 16, "rst_regrant");

    // Both requesting; hold not yet met so owner 0 stays, then reset again.
    goto(r + 30);
    req   = 2'b11;
    data0 = 16'h0123;
    data1 = 16'h4567;
    expect_frame(r + 32, 2'b01, 16'h0123, 1'b1, 4, "tie_pre");
    goto(r + 36);
    reset = 1'b0;
    expect_blank(r + 36, "rst_tie");
    expect_blank(r + 37, "rst_tie");
    expect_blank(r + 38, "rst_tie");
    goto(r + 38);
    base3 = cyc;
    reset = 1'b1;

    // Round robin from idle after reset with hold of two frames.
    expect_frame(base3,      2'b00, 16'h0,    1'b0, 16, "rr_idle");
    expect_frame(base3 + 16, 2'b01, 16'h0123, 1'b1, 16, "rr_0a");
    expect_frame(base3 + 32, 2'b01, 16'h0123, 1'b1, 16, "rr_0b");
    expect_frame(base3 + 48, 2'b10, 16'h4567, 1'b1, 16, "rr_1a");
    expect_frame(base3 + 64, 2'b10, 16'h4567, 1'b1, 16, "rr_1b");
    expect_frame(base3 + 80, 2'b01, 16'h0123, 1'b1, 16, "rr_0c");

    // Owner 0 releases to 1, then owner 1 drops mid-frame into idle.
    goto(base3 + 88);
    req = 2'b10;
    expect_frame(base3 + 96, 2'b10, 16'h4567, 1'b1, 16, "drop_own1");
    goto(base3 + 102);
    req = 2'b00;
    expect_frame(base3 + 112, 2'b00, 16'h0, 1'b1, 16, "drop_idle");
    expect_frame(base3 + 128, 2'b00, 16'h0, 1'b1, 1,  "idle_fd");
    goto(base3 + 130);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
